// File: rtl/buffet_arb_pkg.sv
// Shared types and helpers for the buffet read arbiter slice.
// IDX_WIDTH / DATA_WIDTH fall back to 16 / 32 when the build does not define them.
`ifndef IDX_WIDTH
`define IDX_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package buffet_arb_pkg;

  localparam int TAG_DEPTH_DEF = 8;

  // ceil(log2(n)), never below 1 so a 1-bit tag still exists for tiny configs
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      w = ((32'd1 << i) < n) ? (i + 1) : w;
    end
    return w;
  endfunction

  typedef struct packed {
    logic [`IDX_WIDTH-1:0] idx;
    logic                  will_update;
    logic                  is_shrink;
  } req_t;

endpackage

// File: rtl/buffet_read_arbiter_if.sv
// Requester-side and buffet-side handshake bundle of the buffet read arbiter.
// The master modport is the arbiter's view; slave is the surrounding PEs and buffet.
`ifndef IDX_WIDTH
`define IDX_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface buffet_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = `IDX_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic [NUM_REQ*IDX_WIDTH-1:0] req_idx;
  logic [NUM_REQ-1:0]           req_will_update;
  logic [NUM_REQ-1:0]           req_is_shrink;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;

  logic [IDX_WIDTH-1:0]         buf_read_idx;
  logic                         buf_read_will_update;
  logic                         buf_is_shrink;
  logic                         buf_read_idx_valid;
  logic                         buf_read_idx_ready;

  logic [DATA_WIDTH-1:0]        buf_read_data;
  logic                         buf_read_data_valid;
  logic                         buf_read_data_ready;

  logic [DATA_WIDTH-1:0]        rsp_data;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;

  modport master (
    input  req_idx, req_will_update, req_is_shrink, req_valid,
    output req_ready,
    output buf_read_idx, buf_read_will_update, buf_is_shrink, buf_read_idx_valid,
    input  buf_read_idx_ready,
    input  buf_read_data, buf_read_data_valid,
    output buf_read_data_ready,
    output rsp_data, rsp_valid,
    input  rsp_ready
  );

  modport slave (
    output req_idx, req_will_update, req_is_shrink, req_valid,
    input  req_ready,
    input  buf_read_idx, buf_read_will_update, buf_is_shrink, buf_read_idx_valid,
    output buf_read_idx_ready,
    output buf_read_data, buf_read_data_valid,
    input  buf_read_data_ready,
    input  rsp_data, rsp_valid,
    output rsp_ready
  );
endinterface

// File: rtl/buffet_tag_fifo.sv
// In-order requester-ID FIFO for outstanding buffet reads.
// Push and pop in the same cycle are legal even when full; pop on empty is ignored.
module buffet_tag_fifo
  import buffet_arb_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF,
  parameter int WIDTH = 2,
  localparam int PW = clog2_min1(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             nreset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == {CW{1'b0}});
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  // a full FIFO only accepts a push when the same cycle frees a slot
  assign push_ok_s  = push_i & (~full_o | pop_i);
  assign pop_ok_s   = pop_i & ~empty_o;

  // occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_q <= pop_ok_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      count_q  <= count_d;
    end
  end

  // tag storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/buffet_read_arbiter.sv
// Round-robin sharing of one buffet read/shrink port, with in-order response steering.
// Optional BUFFET_ARB_PERF_EN adds saturating grant and stall counters.
`ifndef IDX_WIDTH
`define IDX_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module buffet_read_arbiter
  import buffet_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = `IDX_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TAG_DEPTH  = TAG_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    nreset_i,
  buffet_read_arbiter_if.master   bus,
  output logic                    err_orphan_rsp
`ifdef BUFFET_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]   perf_grant_cnt,
  output logic [15:0]             perf_stall_cnt
`endif
);

  localparam int TW = clog2_min1(NUM_REQ);
  localparam int CW = clog2_min1(TAG_DEPTH) + 1;

  logic [TW-1:0]      rr_ptr_q;
  logic [TW-1:0]      rr_ptr_d;
  logic [TW-1:0]      sel_s;
  logic [TW-1:0]      cand_s;
  logic [TW-1:0]      head_s;
  logic [NUM_REQ-1:0] elig_s;
  logic               any_s;
  logic               issue_s;
  logic               push_s;
  logic               pop_s;
  logic [CW-1:0]      tag_count_s;
  logic               tag_full_s;
  logic               tag_empty_s;
  logic               err_q;
  req_t               sel_req_s;

  // reads need a free tag slot; shrinks never produce a response
  assign elig_s = bus.req_valid & (bus.req_is_shrink | {NUM_REQ{~tag_full_s}});

  // round-robin pick: scanning offsets high to low leaves the nearest eligible one selected
  always_comb begin
    sel_s  = rr_ptr_q;
    cand_s = rr_ptr_q;
    any_s  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = TW'((int'(rr_ptr_q) + k) % NUM_REQ);
      sel_s  = elig_s[cand_s] ? cand_s : sel_s;
      any_s  = any_s | elig_s[cand_s];
    end
  end

  assign sel_req_s.idx         = bus.req_idx[int'(sel_s)*IDX_WIDTH +: IDX_WIDTH];
  assign sel_req_s.will_update = bus.req_will_update[sel_s];
  assign sel_req_s.is_shrink   = bus.req_is_shrink[sel_s];

  assign bus.buf_read_idx         = sel_req_s.idx;
  assign bus.buf_read_will_update = sel_req_s.will_update;
  assign bus.buf_is_shrink        = sel_req_s.is_shrink;
  assign bus.buf_read_idx_valid   = any_s;

  assign issue_s = any_s & bus.buf_read_idx_ready;
  assign push_s  = issue_s & ~sel_req_s.is_shrink;

  // grant back to the selected requester only
  always_comb begin
    bus.req_ready = {NUM_REQ{1'b0}};
    if (issue_s) begin
      bus.req_ready[sel_s] = 1'b1;
    end else begin
      bus.req_ready = {NUM_REQ{1'b0}};
    end
  end

  // pointer advances past the winner only on an accepted request
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue_s) begin
      rr_ptr_d = (sel_s == TW'(NUM_REQ - 1)) ? {TW{1'b0}} : (sel_s + TW'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // arbitration pointer and sticky orphan flag
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      rr_ptr_q <= {TW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_q | (bus.buf_read_data_valid & (tag_count_s == {CW{1'b0}}));
    end
  end

  assign err_orphan_rsp = err_q;

  buffet_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk         (clk),
    .nreset_i    (nreset_i),
    .push_i      (push_s),
    .push_data_i (sel_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .count_o     (tag_count_s),
    .full_o      (tag_full_s),
    .empty_o     (tag_empty_s)
  );

  assign bus.rsp_data            = bus.buf_read_data;
  assign bus.buf_read_data_ready = ~tag_empty_s & bus.rsp_ready[head_s];
  assign pop_s                   = bus.buf_read_data_valid & bus.buf_read_data_ready;

  // steer the response to the oldest outstanding requester
  always_comb begin
    bus.rsp_valid = {NUM_REQ{1'b0}};
    if (bus.buf_read_data_valid & ~tag_empty_s) begin
      bus.rsp_valid[head_s] = 1'b1;
    end else begin
      bus.rsp_valid = {NUM_REQ{1'b0}};
    end
  end

`ifdef BUFFET_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;
  logic [15:0]              stall_cnt_q;

  // saturating grant and stall counters
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      grant_cnt_q <= '{default: 16'd0};
      stall_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue_s && (sel_s == TW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
      if (any_s && !bus.buf_read_idx_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_buffet_read_arbiter.sv
// Randomized and directed bench for buffet_read_arbiter against a queue-based reference model.
// The bench also plays the in-order buffet, returning {~idx, idx} for each read.
`ifndef IDX_WIDTH
`define IDX_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_buffet_read_arbiter;
  localparam int NR = 4;
  localparam int IW = `IDX_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int TD = 8;

  typedef struct {
    int            req;
    logic [IW-1:0] idx;
  } ent_t;

  logic clk = 1'b0;
  logic nreset_i = 1'b0;
  logic err;
`ifdef BUFFET_ARB_PERF_EN
  logic [NR*16-1:0] perf_g;
  logic [15:0]      perf_s;
`endif

  always #5 clk = ~clk;

  buffet_read_arbiter_if #(.NUM_REQ(NR), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  buffet_read_arbiter #(.NUM_REQ(NR), .IDX_WIDTH(IW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk            (clk),
    .nreset_i       (nreset_i),
    .bus            (bus),
    .err_orphan_rsp (err)
`ifdef BUFFET_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_g),
    .perf_stall_cnt (perf_s)
`endif
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   m_rr = 0;
  bit   m_err = 1'b0;
  ent_t m_q[$];
  int   grant_log[$];
  int   rsp_log[$];
  bit   rsp_en = 1'b0;
  bit   orphan_mode = 1'b0;
  int   rsp_pct = 100;

  function automatic logic [DW-1:0] fdat(input logic [IW-1:0] i);
    return {~i, i};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitration and response routing derived from queue occupancy.
  task automatic model_step();
    int  cnt;
    bit  any;
    int  sel;
    int  head;
    cnt  = m_q.size();
    any  = 1'b0;
    sel  = 0;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_rr + k) % NR;
      if (!any && bus.req_valid[j] && (bus.req_is_shrink[j] || cnt < TD)) begin
        any = 1'b1;
        sel = j;
      end
    end
    chk("idx_valid", bus.buf_read_idx_valid, any);
    chk("req_ready", bus.req_ready, (any && bus.buf_read_idx_ready) ? (1 << sel) : 0);
    if (any) begin
      chk("buf_idx", bus.buf_read_idx, bus.req_idx[sel*IW +: IW]);
      chk("buf_will_update", bus.buf_read_will_update, bus.req_will_update[sel]);
      chk("buf_is_shrink", bus.buf_is_shrink, bus.req_is_shrink[sel]);
    end
    head = (cnt > 0) ? m_q[0].req : 0;
    chk("rsp_valid", bus.rsp_valid, (cnt > 0 && bus.buf_read_data_valid) ? (1 << head) : 0);
    chk("data_ready", bus.buf_read_data_ready, (cnt > 0) && bus.rsp_ready[head]);
    chk("err_orphan", err, m_err);
    if (cnt > 0 && bus.buf_read_data_valid && bus.rsp_ready[head]) begin
      chk("rsp_data", bus.rsp_data, fdat(m_q[0].idx));
      rsp_log.push_back(head);
      void'(m_q.pop_front());
    end
    if (bus.buf_read_data_valid && cnt == 0) m_err = 1'b1;
    if (any && bus.buf_read_idx_ready) begin
      grant_log.push_back(sel);
      m_rr = (sel + 1) % NR;
      if (!bus.req_is_shrink[sel]) m_q.push_back('{req: sel, idx: bus.req_idx[sel*IW +: IW]});
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!nreset_i) begin
        m_rr  = 0;
        m_err = 1'b0;
        m_q.delete();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_data_ready", bus.buf_read_data_ready, 0);
        chk("rst_err", err, 0);
      end else begin
        model_step();
      end
    end
  end

  // Bench buffet: in-order response driver, updated just after the main stimulus.
  initial begin
    bus.buf_read_data_valid = 1'b0;
    bus.buf_read_data       = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.buf_read_data_valid = rsp_en && (orphan_mode ||
                                (m_q.size() > 0 && $urandom_range(0, 99) < rsp_pct));
      bus.buf_read_data = (m_q.size() > 0) ? fdat(m_q[0].idx) : 32'h0BAD_F00D;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid       = '0;
    bus.req_is_shrink   = '0;
    bus.req_will_update = '0;
    bus.req_idx         = '0;
  endtask

  task automatic set_req(input int r, input bit shr, input bit wu, input logic [IW-1:0] idx);
    bus.req_valid[r]          = 1'b1;
    bus.req_is_shrink[r]      = shr;
    bus.req_will_update[r]    = wu;
    bus.req_idx[r*IW +: IW]   = idx;
  endtask

  task automatic do_reset();
    nreset_i    = 1'b0;
    rsp_en      = 1'b0;
    orphan_mode = 1'b0;
    rsp_pct     = 100;
    clear_reqs();
    bus.rsp_ready = '1;
    bus.buf_read_idx_ready = 1'b0;
    step();
    step();
    nreset_i = 1'b1;
    grant_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    clear_reqs();
    bus.rsp_ready = '1;
    bus.buf_read_idx_ready = 1'b0;
    do_reset();

    // stall stability: req0 and req2 held while the buffet is not ready
    set_req(0, 1'b0, 1'b0, 16'h0A00);
    set_req(2, 1'b0, 1'b1, 16'h0A02);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", bus.req_ready, 4'b0000);
      chk("stall_idx", bus.buf_read_idx, 16'h0A00);
      chk("stall_valid", bus.buf_read_idx_valid, 1'b1);
      step();
    end
    bus.buf_read_idx_ready = 1'b1;
    @(negedge clk);
    chk("stall_release0", bus.req_ready, 4'b0001);
    step();
    @(negedge clk);
    chk("stall_release2", bus.req_ready, 4'b0100);
    chk("stall_release2_idx", bus.buf_read_idx, 16'h0A02);
    step();
    clear_reqs();
    step();
    chk("stall_grants", grant_log.size(), 2);

    // round-robin fairness with all four requesters streaming
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, IW'(r));
    bus.buf_read_idx_ready = 1'b1;
    rsp_en = 1'b1;
    repeat (12) step();
    clear_reqs();
    repeat (10) step();
    chk("rr_grant_count", grant_log.size(), 12);
    chk("rr_rsp_count", rsp_log.size(), 12);
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant_order", grant_log[i], i % 4);
      chk("rr_rsp_order", rsp_log[i], i % 4);
    end

    // tag full: reads masked at eight outstanding, shrink still passes
    do_reset();
    bus.buf_read_idx_ready = 1'b1;
    set_req(1, 1'b0, 1'b0, 16'h1111);
    repeat (10) step();
    @(negedge clk);
    chk("full_valid", bus.buf_read_idx_valid, 1'b0);
    chk("full_req_ready", bus.req_ready, 4'b0000);
    step();
    set_req(3, 1'b1, 1'b0, 16'h0003);
    @(negedge clk);
    chk("full_shrink_valid", bus.buf_read_idx_valid, 1'b1);
    chk("full_shrink_flag", bus.buf_is_shrink, 1'b1);
    chk("full_shrink_ready", bus.req_ready, 4'b1000);
    step();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("full_after_shrink", bus.buf_read_idx_valid, 1'b0);
    chk("full_grants", grant_log.size(), 9);
    // drain from full while req1 keeps issuing (pop at full, then push+pop)
    step();
    rsp_en = 1'b1;
    repeat (20) step();
    clear_reqs();
    repeat (16) step();
    chk("full_drained", rsp_log.size(), grant_log.size() - 1);

    // response back-pressure on head tag 2
    do_reset();
    bus.buf_read_idx_ready = 1'b1;
    set_req(2, 1'b0, 1'b0, 16'h0B02);
    step();
    clear_reqs();
    bus.rsp_ready = 4'b1011;
    rsp_en = 1'b1;
    step();
    repeat (3) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("bp_data_ready", bus.buf_read_data_ready, 1'b0);
      step();
    end
    bus.rsp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_release_ready", bus.buf_read_data_ready, 1'b1);
    chk("bp_release_data", bus.rsp_data, 32'hF4FD_0B02);
    step();
    @(negedge clk);
    chk("bp_after_pop_valid", bus.rsp_valid, 4'b0000);
    chk("bp_after_pop_ready", bus.buf_read_data_ready, 1'b0);
    step();

    // orphan response at zero outstanding
    do_reset();
    rsp_en = 1'b1;
    orphan_mode = 1'b1;
    @(negedge clk);
    chk("orphan_pre_err", err, 1'b0);
    chk("orphan_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("orphan_data_ready", bus.buf_read_data_ready, 1'b0);
    step();
    @(negedge clk);
    chk("orphan_err_set", err, 1'b1);
    step();
    orphan_mode = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("orphan_err_sticky", err, 1'b1);
    step();

    // asynchronous reset with reads outstanding
    do_reset();
    bus.buf_read_idx_ready = 1'b1;
    for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, IW'(16'h0C00 + r));
    repeat (4) step();
    bus.buf_read_idx_ready = 1'b0;
    rsp_en = 1'b1;
    @(negedge clk);
    chk("mid_pre_rsp_valid", bus.rsp_valid, 4'b0001);
    step();
    nreset_i = 1'b0;
    #1;
    chk("mid_async_rsp_valid", bus.rsp_valid, 4'b0000);
    @(negedge clk);
    chk("mid_rst_idx", bus.buf_read_idx, 16'h0C00);
    step();
    grant_log.delete();
    nreset_i = 1'b1;
    bus.buf_read_idx_ready = 1'b1;
    step();
    clear_reqs();
    step();
    chk("mid_first_grant_cnt", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("mid_first_grant", grant_log[0], 0);

    // randomized traffic
    do_reset();
    rsp_en = 1'b1;
    rsp_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NR; r++) begin
        bus.req_valid[r]        = ($urandom_range(0, 99) < 60);
        bus.req_is_shrink[r]    = ($urandom_range(0, 99) < 25);
        bus.req_will_update[r]  = $urandom_range(0, 1);
        bus.req_idx[r*IW +: IW] = IW'($urandom);
      end
      bus.buf_read_idx_ready = ($urandom_range(0, 99) < 70);
      bus.rsp_ready          = NR'($urandom);
      step();
    end
    clear_reqs();
    bus.rsp_ready = '1;
    rsp_pct = 100;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
